// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register with write-back data selection
//
// Purpose:
//   Registers the MEM-stage results on each capture edge and drives the
//   write-back ports of the GPR file and the HI/LO registers. The outputs are
//   combinational, but they depend only on the WB register.
//   Edge priority: rst > flush > stall > capture.
//
// Optional feature:
//   WB_RETIRE_CNT_EN - when defined, this adds the retire_cnt output. The
//                      counter increments on every capture of a valid
//                      instruction.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mem_valid           MEM stage holds a real instruction
//   stall, flush        hold WB register / load a bubble
//   mem_*_wena          MEM-stage write enables (GPR, HI, LO)
//   mem_rf_waddr        destination GPR
//   mem_*_mux_sel       write-data selects
//   mem_* (32-bit)      candidate results
//   rf_wena/waddr/wdata GPR write port
//   hi_wena/hi_wdata    HI write port
//   lo_wena/lo_wdata    LO write port
//   wb_valid            WB register holds a real instruction
//   retire_cnt          retired-instruction count (WB_RETIRE_CNT_EN only)

module wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_rf_wena,
  input  logic        mem_hi_wena,
  input  logic        mem_lo_wena,
  input  logic [4:0]  mem_rf_waddr,
  input  logic [2:0]  mem_rf_mux_sel,
  input  logic [1:0]  mem_hi_mux_sel,
  input  logic [1:0]  mem_lo_mux_sel,
  input  logic [31:0] mem_lo_out,
  input  logic [31:0] mem_pc4,
  input  logic [31:0] mem_clz_out,
  input  logic [31:0] mem_dmem_out,
  input  logic [31:0] mem_alu_out,
  input  logic [31:0] mem_hi_out,
  input  logic [31:0] mem_mul_lo,
  input  logic [31:0] mem_mul_hi,
  input  logic [31:0] mem_div_r,
  input  logic [31:0] mem_div_q,
  input  logic [31:0] mem_rs_data_out,
  output logic        rf_wena,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        hi_wena,
  output logic        lo_wena,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        wb_valid
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_cnt
`endif
);

  logic        valid_q;
  logic        rf_wena_q;
  logic        hi_wena_q;
  logic        lo_wena_q;
  logic [4:0]  waddr_q;
  logic [2:0]  rf_sel_q;
  logic [1:0]  hi_sel_q;
  logic [1:0]  lo_sel_q;
  logic [31:0] lo_out_q;
  logic [31:0] pc4_q;
  logic [31:0] clz_out_q;
  logic [31:0] dmem_out_q;
  logic [31:0] alu_out_q;
  logic [31:0] hi_out_q;
  logic [31:0] mul_lo_q;
  logic [31:0] mul_hi_q;
  logic [31:0] div_r_q;
  logic [31:0] div_q_q;
  logic [31:0] rs_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      rf_wena_q  <= 1'b0;
      hi_wena_q  <= 1'b0;
      lo_wena_q  <= 1'b0;
      waddr_q    <= '0;
      rf_sel_q   <= '0;
      hi_sel_q   <= '0;
      lo_sel_q   <= '0;
      lo_out_q   <= '0;
      pc4_q      <= '0;
      clz_out_q  <= '0;
      dmem_out_q <= '0;
      alu_out_q  <= '0;
      hi_out_q   <= '0;
      mul_lo_q   <= '0;
      mul_hi_q   <= '0;
      div_r_q    <= '0;
      div_q_q    <= '0;
      rs_data_q  <= '0;
    end else if (flush) begin
      // Only the control bits must be cleared. The data is left untouched.
      valid_q   <= 1'b0;
      rf_wena_q <= 1'b0;
      hi_wena_q <= 1'b0;
      lo_wena_q <= 1'b0;
    end else if (!stall) begin
      valid_q    <= mem_valid;
      rf_wena_q  <= mem_rf_wena;
      hi_wena_q  <= mem_hi_wena;
      lo_wena_q  <= mem_lo_wena;
      waddr_q    <= mem_rf_waddr;
      rf_sel_q   <= mem_rf_mux_sel;
      hi_sel_q   <= mem_hi_mux_sel;
      lo_sel_q   <= mem_lo_mux_sel;
      lo_out_q   <= mem_lo_out;
      pc4_q      <= mem_pc4;
      clz_out_q  <= mem_clz_out;
      dmem_out_q <= mem_dmem_out;
      alu_out_q  <= mem_alu_out;
      hi_out_q   <= mem_hi_out;
      mul_lo_q   <= mem_mul_lo;
      mul_hi_q   <= mem_mul_hi;
      div_r_q    <= mem_div_r;
      div_q_q    <= mem_div_q;
      rs_data_q  <= mem_rs_data_out;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (!flush && !stall && mem_valid) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

  always_comb begin
    rf_wdata = '0;
    case (rf_sel_q)
      3'd0:    rf_wdata = lo_out_q;
      3'd1:    rf_wdata = pc4_q;
      3'd2:    rf_wdata = clz_out_q;
      3'd3:    rf_wdata = '0;
      3'd4:    rf_wdata = dmem_out_q;
      3'd5:    rf_wdata = alu_out_q;
      3'd6:    rf_wdata = hi_out_q;
      default: rf_wdata = mul_lo_q;
    endcase
  end

  always_comb begin
    hi_wdata = '0;
    case (hi_sel_q)
      2'd0:    hi_wdata = div_r_q;
      2'd1:    hi_wdata = mul_hi_q;
      2'd2:    hi_wdata = rs_data_q;
      default: hi_wdata = '0;
    endcase
  end

  always_comb begin
    lo_wdata = '0;
    case (lo_sel_q)
      2'd0:    lo_wdata = div_q_q;
      2'd1:    lo_wdata = mul_lo_q;
      2'd2:    lo_wdata = rs_data_q;
      default: lo_wdata = '0;
    endcase
  end

  // $0 is hard-wired to zero, so a write to it is never asserted.
  assign rf_wena  = rf_wena_q & valid_q & (waddr_q != 5'd0);
  assign hi_wena  = hi_wena_q & valid_q;
  assign lo_wena  = lo_wena_q & valid_q;
  assign rf_waddr = waddr_q;
  assign wb_valid = valid_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard testbench for wb_stage

module tb_wb_stage;

  typedef struct {
    logic        valid;
    logic        rf_we;
    logic        hi_we;
    logic        lo_we;
    logic [4:0]  waddr;
    logic [2:0]  rf_sel;
    logic [1:0]  hi_sel;
    logic [1:0]  lo_sel;
    logic [31:0] lo_out, pc4, clz, dmem, alu, hi_out, mul_lo, mul_hi, div_r, div_q, rs;
  } in_t;

  typedef struct {
    logic        valid;
    logic        rf_wena;
    logic        hi_wena;
    logic        lo_wena;
    logic        data_chk;
    logic [4:0]  waddr;
    logic [31:0] rf_wdata;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, mem_valid, stall, flush;
  logic        mem_rf_wena, mem_hi_wena, mem_lo_wena;
  logic [4:0]  mem_rf_waddr;
  logic [2:0]  mem_rf_mux_sel;
  logic [1:0]  mem_hi_mux_sel, mem_lo_mux_sel;
  logic [31:0] mem_lo_out, mem_pc4, mem_clz_out, mem_dmem_out, mem_alu_out, mem_hi_out;
  logic [31:0] mem_mul_lo, mem_mul_hi, mem_div_r, mem_div_q, mem_rs_data_out;
  logic        rf_wena, hi_wena, lo_wena, wb_valid;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, hi_wdata, lo_wdata;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  exp_t cur;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .stall(stall), .flush(flush),
    .mem_rf_wena(mem_rf_wena), .mem_hi_wena(mem_hi_wena), .mem_lo_wena(mem_lo_wena),
    .mem_rf_waddr(mem_rf_waddr), .mem_rf_mux_sel(mem_rf_mux_sel),
    .mem_hi_mux_sel(mem_hi_mux_sel), .mem_lo_mux_sel(mem_lo_mux_sel),
    .mem_lo_out(mem_lo_out), .mem_pc4(mem_pc4), .mem_clz_out(mem_clz_out),
    .mem_dmem_out(mem_dmem_out), .mem_alu_out(mem_alu_out), .mem_hi_out(mem_hi_out),
    .mem_mul_lo(mem_mul_lo), .mem_mul_hi(mem_mul_hi), .mem_div_r(mem_div_r),
    .mem_div_q(mem_div_q), .mem_rs_data_out(mem_rs_data_out),
    .rf_wena(rf_wena), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .hi_wena(hi_wena), .lo_wena(lo_wena), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .wb_valid(wb_valid)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic in_t blank();
    in_t s;
    s.valid = 1'b1; s.rf_we = 1'b0; s.hi_we = 1'b0; s.lo_we = 1'b0;
    s.waddr = '0; s.rf_sel = '0; s.hi_sel = '0; s.lo_sel = '0;
    s.lo_out = 32'h1000_0000; s.pc4 = 32'h1000_0001; s.clz = 32'h1000_0002;
    s.dmem = 32'h1000_0004; s.alu = 32'h1000_0005; s.hi_out = 32'h1000_0006;
    s.mul_lo = 32'h1000_0007; s.mul_hi = 32'h2000_0001; s.div_r = 32'h2000_0000;
    s.div_q = 32'h3000_0000; s.rs = 32'h4000_0002;
    return s;
  endfunction

  function automatic in_t rand_in();
    in_t s;
    s.valid = 1'($urandom); s.rf_we = 1'($urandom); s.hi_we = 1'($urandom);
    s.lo_we = 1'($urandom); s.waddr = 5'($urandom); s.rf_sel = 3'($urandom);
    s.hi_sel = 2'($urandom); s.lo_sel = 2'($urandom);
    s.lo_out = $urandom; s.pc4 = $urandom; s.clz = $urandom; s.dmem = $urandom;
    s.alu = $urandom; s.hi_out = $urandom; s.mul_lo = $urandom; s.mul_hi = $urandom;
    s.div_r = $urandom; s.div_q = $urandom; s.rs = $urandom;
    return s;
  endfunction

  // Expected outputs after a plain capture of s.
  function automatic exp_t capture_exp(in_t s, logic [31:0] cnt);
    exp_t e;
    e.valid    = s.valid;
    e.rf_wena  = s.rf_we & s.valid & (s.waddr != 5'd0);
    e.hi_wena  = s.hi_we & s.valid;
    e.lo_wena  = s.lo_we & s.valid;
    e.data_chk = 1'b1;
    e.waddr    = s.waddr;
    case (s.rf_sel)
      3'd0: e.rf_wdata = s.lo_out;
      3'd1: e.rf_wdata = s.pc4;
      3'd2: e.rf_wdata = s.clz;
      3'd3: e.rf_wdata = 32'h0;
      3'd4: e.rf_wdata = s.dmem;
      3'd5: e.rf_wdata = s.alu;
      3'd6: e.rf_wdata = s.hi_out;
      default: e.rf_wdata = s.mul_lo;
    endcase
    case (s.hi_sel)
      2'd0: e.hi_wdata = s.div_r;
      2'd1: e.hi_wdata = s.mul_hi;
      2'd2: e.hi_wdata = s.rs;
      default: e.hi_wdata = 32'h0;
    endcase
    case (s.lo_sel)
      2'd0: e.lo_wdata = s.div_q;
      2'd1: e.lo_wdata = s.mul_lo;
      2'd2: e.lo_wdata = s.rs;
      default: e.lo_wdata = 32'h0;
    endcase
    e.cnt = cnt + {31'd0, s.valid};
    return e;
  endfunction

  task automatic step(input string tag, input in_t s, input logic st, input logic fl, input logic r);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst = r; stall = st; flush = fl;
    mem_valid = s.valid; mem_rf_wena = s.rf_we; mem_hi_wena = s.hi_we; mem_lo_wena = s.lo_we;
    mem_rf_waddr = s.waddr; mem_rf_mux_sel = s.rf_sel;
    mem_hi_mux_sel = s.hi_sel; mem_lo_mux_sel = s.lo_sel;
    mem_lo_out = s.lo_out; mem_pc4 = s.pc4; mem_clz_out = s.clz; mem_dmem_out = s.dmem;
    mem_alu_out = s.alu; mem_hi_out = s.hi_out; mem_mul_lo = s.mul_lo;
    mem_mul_hi = s.mul_hi; mem_div_r = s.div_r; mem_div_q = s.div_q; mem_rs_data_out = s.rs;
    if (r) begin
      e.valid = 1'b0; e.rf_wena = 1'b0; e.hi_wena = 1'b0; e.lo_wena = 1'b0;
      e.data_chk = 1'b1; e.waddr = '0; e.rf_wdata = '0; e.hi_wdata = '0;
      e.lo_wdata = '0; e.cnt = '0;
    end else if (fl) begin
      e = cur;
      e.valid = 1'b0; e.rf_wena = 1'b0; e.hi_wena = 1'b0; e.lo_wena = 1'b0;
      e.data_chk = 1'b0;
    end else if (st) begin
      e = cur;
    end else begin
      e = capture_exp(s, cur.cnt);
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check({tag, ".wb_valid"}, {31'd0, wb_valid}, {31'd0, got.valid});
    check({tag, ".rf_wena"},  {31'd0, rf_wena},  {31'd0, got.rf_wena});
    check({tag, ".hi_wena"},  {31'd0, hi_wena},  {31'd0, got.hi_wena});
    check({tag, ".lo_wena"},  {31'd0, lo_wena},  {31'd0, got.lo_wena});
    if (got.data_chk) begin
      check({tag, ".rf_waddr"}, {27'd0, rf_waddr}, {27'd0, got.waddr});
      check({tag, ".rf_wdata"}, rf_wdata, got.rf_wdata);
      check({tag, ".hi_wdata"}, hi_wdata, got.hi_wdata);
      check({tag, ".lo_wdata"}, lo_wdata, got.lo_wdata);
    end
`ifdef WB_RETIRE_CNT_EN
    check({tag, ".retire_cnt"}, retire_cnt, got.cnt);
`endif
    cur = got;
  endtask

  initial begin
    in_t s;
    cur.cnt = '0; cur.valid = 1'b0; cur.rf_wena = 1'b0; cur.hi_wena = 1'b0;
    cur.lo_wena = 1'b0; cur.data_chk = 1'b0; cur.waddr = '0;
    cur.rf_wdata = '0; cur.hi_wdata = '0; cur.lo_wdata = '0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;

    s = blank();
    step("reset0", s, 1'b0, 1'b0, 1'b1);
    step("reset1", s, 1'b1, 1'b1, 1'b1);

    // ALU capture
    s = blank(); s.rf_we = 1'b1; s.waddr = 5'd8; s.rf_sel = 3'd5; s.alu = 32'h1234_5678;
    step("alu", s, 1'b0, 1'b0, 1'b0);

    // $0 suppression
    s = blank(); s.rf_we = 1'b1; s.waddr = 5'd0; s.rf_sel = 3'd4; s.dmem = 32'hDEAD_BEEF;
    step("zero_reg", s, 1'b0, 1'b0, 1'b0);

    // Multiply writes HI and LO in the same cycle
    s = blank(); s.hi_we = 1'b1; s.lo_we = 1'b1; s.hi_sel = 2'd1; s.lo_sel = 2'd1;
    s.mul_hi = 32'h1; s.mul_lo = 32'hFFFF_FFFE;
    step("mult", s, 1'b0, 1'b0, 1'b0);

    // Walk every GPR select with a fixed destination
    for (int i = 0; i < 8; i++) begin
      s = blank(); s.rf_we = 1'b1; s.waddr = 5'd31; s.rf_sel = 3'(i);
      step($sformatf("rfsel%0d", i), s, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      s = blank(); s.hi_we = 1'b1; s.lo_we = 1'b1; s.hi_sel = 2'(i); s.lo_sel = 2'(i);
      step($sformatf("hilosel%0d", i), s, 1'b0, 1'b0, 1'b0);
    end

    // Stall holds the captured value, then flush wins over stall
    s = blank(); s.rf_we = 1'b1; s.waddr = 5'd3; s.rf_sel = 3'd5; s.alu = 32'hA;
    step("pre_stall", s, 1'b0, 1'b0, 1'b0);
    s.waddr = 5'd4; s.alu = 32'hB;
    step("stall0", s, 1'b1, 1'b0, 1'b0);
    step("stall1", s, 1'b1, 1'b0, 1'b0);
    step("flush_stall", s, 1'b1, 1'b1, 1'b0);
    step("post_flush_stall", s, 1'b1, 1'b0, 1'b0);

    // Bubble capture
    s = blank(); s.valid = 1'b0; s.rf_we = 1'b1; s.hi_we = 1'b1; s.waddr = 5'd9;
    step("bubble", s, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of operation
    s = blank(); s.rf_we = 1'b1; s.waddr = 5'd12; s.rf_sel = 3'd1;
    step("pre_rst", s, 1'b0, 1'b0, 1'b0);
    step("mid_rst", s, 1'b1, 1'b0, 1'b1);
    step("first_capture", s, 1'b0, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      s = rand_in();
      step("rand", s, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 19) == 0));
    end

    if (sb_q.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
